// File: rtl/dram_cmd_scheduler_if.sv
// dram_cmd_scheduler_if
// Request and command bus between a CPU-side requester, the DRAM command
// scheduler and the downstream command logger/PHY stage.
//
// Signals:
//   req_valid / req_ready  request handshake (requester -> scheduler)
//   req_op                 0 read, 1 write, 2 ifetch (read), 3 invalid
//   req_addr               request address
//   req_err                one-cycle pulse when an invalid op is accepted
//   cmd_valid              one-cycle pulse per issued DRAM command
//   cmd_type               0 PRE, 1 ACT, 2 RD, 3 WR
//   cmd_bg / cmd_bank      target bank group / bank
//   cmd_row / cmd_col      row (for ACT) / column (for RD, WR)
//   q_count                occupied request queue entries
//   busy                   queue non-empty or scheduler not idle
//
// Modports:
//   master  the requester / observer side
//   slave   the scheduler side

interface dram_cmd_scheduler_if #(
  parameter int QUEUE_DEPTH = 16,
  parameter int ADDR_W      = 36,
  parameter int NUM_BG      = 4,
  parameter int NUM_BANKS   = 4,
  parameter int COL_LSB     = 10,
  parameter int ROW_LSB     = 18
);

  localparam int BG_W   = $clog2(NUM_BG);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int COL_W  = ROW_LSB - COL_LSB;
  localparam int ROW_W  = ADDR_W - ROW_LSB;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic              req_err;

  logic              cmd_valid;
  logic [1:0]        cmd_type;
  logic [BG_W-1:0]   cmd_bg;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;

  logic [CNT_W-1:0]  q_count;
  logic              busy;

  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, req_err,
    input  cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col,
    input  q_count, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, req_err,
    output cmd_valid, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_col,
    output q_count, busy
  );

endinterface

// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
// In-order DRAM command scheduler. CPU requests are buffered in a circular
// request queue; the head request is turned into PRE/ACT/RD/WR commands
// using an open-page policy, with per-bank open-row tracking and timing
// spacing for tRCD, tRP, tCCD_L, tRTP and tWR (all in controller clocks).
//
// Ports:
//   clk    controller clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dram_cmd_scheduler_if.slave: request handshake in, command
//          stream, queue occupancy and busy status out

module dram_cmd_scheduler #(
  parameter int QUEUE_DEPTH = 16,
  parameter int ADDR_W      = 36,
  parameter int NUM_BG      = 4,
  parameter int NUM_BANKS   = 4,
  parameter int BG_LSB      = 6,
  parameter int BANK_LSB    = 8,
  parameter int COL_LSB     = 10,
  parameter int ROW_LSB     = 18,
  parameter int T_RCD       = 48,
  parameter int T_RP        = 48,
  parameter int T_CCD_L     = 16,
  parameter int T_RTP       = 24,
  parameter int T_WR        = 40
) (
  input logic                 clk,
  input logic                 rst_n,
  dram_cmd_scheduler_if.slave bus
);

  localparam int BG_W        = $clog2(NUM_BG);
  localparam int BANK_W      = $clog2(NUM_BANKS);
  localparam int COL_W       = ROW_LSB - COL_LSB;
  localparam int ROW_W       = ADDR_W - ROW_LSB;
  localparam int CNT_W       = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int NUM_ENTRIES = NUM_BG * NUM_BANKS;
  localparam int IDX_W       = BG_W + BANK_W;

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  // The gap counter only needs to reach the longest constraint it guards.
  localparam int GAP_MAX = (T_WR > T_RTP) ? ((T_WR > T_CCD_L) ? T_WR : T_CCD_L)
                                          : ((T_RTP > T_CCD_L) ? T_RTP : T_CCD_L);
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(GAP_MAX);

  // The gap is cleared on the RD/WR edge and compared with its value before
  // the candidate edge, so an edge N cycles after the RD/WR sees N-1.
  localparam logic [GAP_W-1:0] WR_THR  = GAP_W'(T_WR - 1);
  localparam logic [GAP_W-1:0] RTP_THR = GAP_W'(T_RTP - 1);
  localparam logic [GAP_W-1:0] CCD_THR = GAP_W'(T_CCD_L - 1);

  // The delay counter is loaded on the issuing edge, the wait state spends
  // one edge observing zero, and the following state issues the command, so
  // loading T-2 places the next command exactly T edges after the first.
  localparam int DLY_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam logic [DLY_W-1:0] RP_LOAD  = DLY_W'(T_RP - 2);
  localparam logic [DLY_W-1:0] RCD_LOAD = DLY_W'(T_RCD - 2);

  typedef enum logic [2:0] {
    IDLE,
    PRE_WAIT,
    ACT_WAIT,
    ACT,
    RW_DELAY,
    RW_WAIT
  } stateT;

  typedef enum logic [1:0] {
    CMD_PRE = 2'd0,
    CMD_ACT = 2'd1,
    CMD_RD  = 2'd2,
    CMD_WR  = 2'd3
  } cmdT;

  stateT             state;

  logic [1:0]        opMem   [QUEUE_DEPTH];
  logic [ADDR_W-1:0] addrMem [QUEUE_DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  qCount;

  logic [NUM_ENTRIES-1:0] bankOpen;
  logic [ROW_W-1:0]       bankRow [NUM_ENTRIES];

  logic [DLY_W-1:0]  dlyCnt;
  logic [GAP_W-1:0]  gap;
  logic              lastWr;

  logic              reqErr;
  logic              cmdValid;
  cmdT               cmdType;
  logic [BG_W-1:0]   cmdBg;
  logic [BANK_W-1:0] cmdBank;
  logic [ROW_W-1:0]  cmdRow;
  logic [COL_W-1:0]  cmdCol;

  logic              reqReady;
  logic              acceptNow;
  logic              pushNow;
  logic              errNow;
  logic              popNow;
  logic              issueNow;
  cmdT               issueType;

  logic [1:0]        headOp;
  logic [ADDR_W-1:0] headAddr;
  logic [BG_W-1:0]   headBg;
  logic [BANK_W-1:0] headBank;
  logic [COL_W-1:0]  headCol;
  logic [ROW_W-1:0]  headRow;
  logic [IDX_W-1:0]  headIdx;
  logic              headIsWrite;
  logic              preGapOk;
  logic              rwGapOk;
  logic              unusedAddrBits;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode: invalid ops complete the handshake but never enter
  // the queue.
  assign reqReady  = (qCount < FULL_CNT);
  assign acceptNow = bus.req_valid && reqReady;
  assign pushNow   = acceptNow && (bus.req_op != 2'd3);
  assign errNow    = acceptNow && (bus.req_op == 2'd3);

  // Head-of-queue field extraction. Bank groups and banks are powers of two,
  // so bg*NUM_BANKS + bank is simply their concatenation.
  assign headOp      = opMem[headPtr];
  assign headAddr    = addrMem[headPtr];
  assign headBg      = headAddr[BG_LSB +: BG_W];
  assign headBank    = headAddr[BANK_LSB +: BANK_W];
  assign headCol     = headAddr[COL_LSB +: COL_W];
  assign headRow     = headAddr[ROW_LSB +: ROW_W];
  assign headIdx     = {headBg, headBank};
  assign headIsWrite = (headOp == 2'd1);

  // Address bits below the bank-group field select bytes within a burst and
  // play no part in scheduling.
  assign unusedAddrBits = ^headAddr;

  assign preGapOk = lastWr ? (gap >= WR_THR) : (gap >= RTP_THR);
  assign rwGapOk  = (gap >= CCD_THR);

  // Decide whether the current state issues a command on the coming edge.
  // The pop of the head is tied to the RD/WR issue.
  always_comb begin
    issueNow  = 1'b0;
    issueType = CMD_PRE;
    case (state)
      PRE_WAIT: begin
        if (preGapOk) begin
          issueNow  = 1'b1;
          issueType = CMD_PRE;
        end
      end
      ACT: begin
        issueNow  = 1'b1;
        issueType = CMD_ACT;
      end
      RW_WAIT: begin
        if (rwGapOk) begin
          issueNow  = 1'b1;
          issueType = headIsWrite ? CMD_WR : CMD_RD;
        end
      end
      default: begin
      end
    endcase
  end

  assign popNow = (state == RW_WAIT) && rwGapOk;

  // Queue storage needs no reset: entries are only read once the pointers
  // say they have been written.
  always_ff @(posedge clk) begin
    if (pushNow) begin
      opMem[tailPtr]   <= bus.req_op;
      addrMem[tailPtr] <= bus.req_addr;
    end
  end

  // Queue pointers, occupancy and the invalid-request pulse. A push and pop
  // on the same edge leave the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      qCount  <= '0;
      reqErr  <= 1'b0;
    end else begin
      reqErr <= errNow;
      if (pushNow) begin
        tailPtr <= nextPtr(tailPtr);
      end
      if (popNow) begin
        headPtr <= nextPtr(headPtr);
      end
      case ({pushNow, popNow})
        2'b10:   qCount <= qCount + 1'b1;
        2'b01:   qCount <= qCount - 1'b1;
        default: begin
        end
      endcase
    end
  end

  // Scheduler FSM with the bank table, timing counters and registered
  // command outputs. The gap counter free-runs to saturation and is cleared
  // by every RD/WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bankOpen <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        bankRow[i] <= '0;
      end
      dlyCnt   <= '0;
      gap      <= GAP_SAT;
      lastWr   <= 1'b0;
      cmdValid <= 1'b0;
      cmdType  <= CMD_PRE;
      cmdBg    <= '0;
      cmdBank  <= '0;
      cmdRow   <= '0;
      cmdCol   <= '0;
    end else begin
      cmdValid <= issueNow;
      if (issueNow) begin
        cmdType <= issueType;
        cmdBg   <= headBg;
        cmdBank <= headBank;
        cmdRow  <= headRow;
        cmdCol  <= headCol;
      end

      if (gap != GAP_SAT) begin
        gap <= gap + 1'b1;
      end

      case (state)
        IDLE: begin
          if (qCount != '0) begin
            if (!bankOpen[headIdx]) begin
              state <= ACT;
            end else if (bankRow[headIdx] == headRow) begin
              state <= RW_WAIT;
            end else begin
              state <= PRE_WAIT;
            end
          end
        end
        PRE_WAIT: begin
          if (preGapOk) begin
            bankOpen[headIdx] <= 1'b0;
            dlyCnt            <= RP_LOAD;
            state             <= ACT_WAIT;
          end
        end
        ACT_WAIT: begin
          if (dlyCnt == '0) begin
            state <= ACT;
          end else begin
            dlyCnt <= dlyCnt - 1'b1;
          end
        end
        ACT: begin
          bankOpen[headIdx] <= 1'b1;
          bankRow[headIdx]  <= headRow;
          dlyCnt            <= RCD_LOAD;
          state             <= RW_DELAY;
        end
        RW_DELAY: begin
          if (dlyCnt == '0) begin
            state <= RW_WAIT;
          end else begin
            dlyCnt <= dlyCnt - 1'b1;
          end
        end
        RW_WAIT: begin
          if (rwGapOk) begin
            gap    <= '0;
            lastWr <= headIsWrite;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.req_err   = reqErr;
  assign bus.cmd_valid = cmdValid;
  assign bus.cmd_type  = cmdType;
  assign bus.cmd_bg    = cmdBg;
  assign bus.cmd_bank  = cmdBank;
  assign bus.cmd_row   = cmdRow;
  assign bus.cmd_col   = cmdCol;
  assign bus.q_count   = qCount;
  assign bus.busy      = (qCount != '0) || (state != IDLE);

endmodule
